// File: rtl/reg_sb_pkg.sv
// reg_sb_pkg
//   Shared definitions for the issue-stage register scoreboard: the
//   write-class enum, the opcode constants that split scalar from vector
//   writers, and the write-class decode. The writeback register-enable
//   logic imports the same function so both sides classify writes alike.
package reg_sb_pkg;

    typedef enum logic [1:0] {
        WR_NONE   = 2'd0,
        WR_SCALAR = 2'd1,
        WR_VECTOR = 2'd2
    } wr_class_t;

    // Compute opcodes up to this value write the scalar file; above it, vector.
    localparam logic [3:0] OPC_SV_BOUND  = 4'd9;
    localparam logic [3:0] OPC_LD_SCALAR = 4'd0;
    localparam logic [3:0] OPC_LD_VECTOR = 4'd2;
    localparam logic [1:0] OPT_MEM       = 2'b10;

    // Register 0 is hard-wired zero, so writes to it never need tracking.
    function automatic wr_class_t decode_wr_class(input logic [1:0] op_type,
                                                  input logic [3:0] op_code,
                                                  input logic [3:0] rd);
        wr_class_t cls;
        cls = WR_NONE;
        if (rd == 4'd0)
            cls = WR_NONE;
        else if (!op_type[1])
            cls = (op_code <= OPC_SV_BOUND) ? WR_SCALAR : WR_VECTOR;
        else if ((op_type == OPT_MEM) && (op_code == OPC_LD_SCALAR))
            cls = WR_SCALAR;
        else if ((op_type == OPT_MEM) && (op_code == OPC_LD_VECTOR))
            cls = WR_VECTOR;
        return cls;
    endfunction

endpackage

// File: rtl/reg_busy_table.sv
// reg_busy_table
//   Busy bitmap for one register file (scalar or vector).
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     i_flush              clear every busy bit at the next edge
//     i_set, i_set_idx     mark a register busy (accepted issue)
//     i_clr, i_clr_idx     writeback release
//     i_rs1, i_rs2, i_rd   lookup indices
//     o_busy               registered bitmap
//     o_rs1/rs2/rd_busy    lookups with this cycle's writeback bypassed
//     o_clr_hit            writeback released a busy register
//     o_spurious           writeback targeted a non-busy register
module reg_busy_table #(
    parameter int NREG = 16,
    parameter int IW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic            i_set,
    input  logic [IW-1:0]   i_set_idx,
    input  logic            i_clr,
    input  logic [IW-1:0]   i_clr_idx,
    input  logic [IW-1:0]   i_rs1,
    input  logic [IW-1:0]   i_rs2,
    input  logic [IW-1:0]   i_rd,
    output logic [NREG-1:0] o_busy,
    output logic            o_rs1_busy,
    output logic            o_rs2_busy,
    output logic            o_rd_busy,
    output logic            o_clr_hit,
    output logic            o_spurious
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_clr_act;

    // A register being written back this cycle already looks free.
    function automatic logic lookup(input logic [NREG-1:0] busy,
                                    input logic [IW-1:0]   idx,
                                    input logic            clr,
                                    input logic [IW-1:0]   clr_idx);
        return (idx != '0) && busy[idx] && !(clr && (clr_idx == idx));
    endfunction

    assign w_clr_act  = i_clr && (i_clr_idx != '0);
    assign o_clr_hit  = w_clr_act && r_busy[i_clr_idx];
    assign o_spurious = w_clr_act && !r_busy[i_clr_idx];

    assign o_rs1_busy = lookup(r_busy, i_rs1, i_clr, i_clr_idx);
    assign o_rs2_busy = lookup(r_busy, i_rs2, i_clr, i_clr_idx);
    assign o_rd_busy  = lookup(r_busy, i_rd,  i_clr, i_clr_idx);

    // Set is applied after clear so a same-register set/clear leaves it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (o_clr_hit)
            w_busy_nxt[i_clr_idx] = 1'b0;
        if (i_set && (i_set_idx != '0))
            w_busy_nxt[i_set_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_busy <= '0;
        else if (i_flush)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Issue-stage scoreboard between decode and execute. Stalls decode on
//   RAW/WAW hazards against pending writes and on the in-flight limit;
//   writebacks release registers.
//   Ports:
//     clk, rst_n                         clock, asynchronous active-low reset
//     issue_valid/opType/opCode/rd       instruction from decode
//     issue_rs1/rs2, _en, _vec           source operands
//     issue_ready                        combinational issue permission
//     wb_s_valid/wb_s_rd                 scalar writeback
//     wb_v_valid/wb_v_rd                 vector writeback
//     flush                              drop all pending tracking
//     busy_s, busy_v                     registered busy bitmaps
//     inflight                           outstanding writing instructions
//     err_spurious                       pulse after a writeback to a free register
module reg_scoreboard
    import reg_sb_pkg::*;
#(
    parameter int NREG         = 16,
    parameter int MAX_INFLIGHT = 8,
    parameter int IFW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [1:0]      issue_opType,
    input  logic [3:0]      issue_opCode,
    input  logic [3:0]      issue_rd,
    input  logic [3:0]      issue_rs1,
    input  logic [3:0]      issue_rs2,
    input  logic            issue_rs1_en,
    input  logic            issue_rs2_en,
    input  logic            issue_rs1_vec,
    input  logic            issue_rs2_vec,
    output logic            issue_ready,
    input  logic            wb_s_valid,
    input  logic [3:0]      wb_s_rd,
    input  logic            wb_v_valid,
    input  logic [3:0]      wb_v_rd,
    input  logic            flush,
    output logic [NREG-1:0] busy_s,
    output logic [NREG-1:0] busy_v,
    output logic [IFW-1:0]  inflight,
    output logic            err_spurious
);

    wr_class_t      w_cls;
    logic           w_s_rs1, w_s_rs2, w_s_rd, w_s_hit, w_s_spur;
    logic           w_v_rs1, w_v_rs2, w_v_rd, w_v_hit, w_v_spur;
    logic           w_raw, w_waw, w_full, w_accept;
    logic           w_set_s, w_set_v;
    logic [IFW-1:0] w_inflight_nxt;
    logic [IFW-1:0] r_inflight;
    logic           r_err;

    assign w_cls = decode_wr_class(issue_opType, issue_opCode, issue_rd);

    assign w_accept = issue_valid && issue_ready;
    assign w_set_s  = w_accept && (w_cls == WR_SCALAR);
    assign w_set_v  = w_accept && (w_cls == WR_VECTOR);

    reg_busy_table #(.NREG(NREG)) u_tbl_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (flush),
        .i_set      (w_set_s),
        .i_set_idx  (issue_rd),
        .i_clr      (wb_s_valid),
        .i_clr_idx  (wb_s_rd),
        .i_rs1      (issue_rs1),
        .i_rs2      (issue_rs2),
        .i_rd       (issue_rd),
        .o_busy     (busy_s),
        .o_rs1_busy (w_s_rs1),
        .o_rs2_busy (w_s_rs2),
        .o_rd_busy  (w_s_rd),
        .o_clr_hit  (w_s_hit),
        .o_spurious (w_s_spur)
    );

    reg_busy_table #(.NREG(NREG)) u_tbl_v (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (flush),
        .i_set      (w_set_v),
        .i_set_idx  (issue_rd),
        .i_clr      (wb_v_valid),
        .i_clr_idx  (wb_v_rd),
        .i_rs1      (issue_rs1),
        .i_rs2      (issue_rs2),
        .i_rd       (issue_rd),
        .o_busy     (busy_v),
        .o_rs1_busy (w_v_rs1),
        .o_rs2_busy (w_v_rs2),
        .o_rd_busy  (w_v_rd),
        .o_clr_hit  (w_v_hit),
        .o_spurious (w_v_spur)
    );

    assign w_raw = (issue_rs1_en && (issue_rs1_vec ? w_v_rs1 : w_s_rs1)) ||
                   (issue_rs2_en && (issue_rs2_vec ? w_v_rs2 : w_s_rs2));

    assign w_waw = ((w_cls == WR_SCALAR) && w_s_rd) ||
                   ((w_cls == WR_VECTOR) && w_v_rd);

    // The limit uses the registered count: a writeback this cycle does not
    // free a slot until the next cycle.
    assign w_full = (w_cls != WR_NONE) && (r_inflight == IFW'(MAX_INFLIGHT));

    assign issue_ready = !flush && !w_raw && !w_waw && !w_full;

    assign w_inflight_nxt = r_inflight + IFW'(w_set_s | w_set_v)
                            - IFW'(w_s_hit) - IFW'(w_v_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else if (flush) begin
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_err      <= w_s_spur | w_v_spur;
        end
    end

    assign inflight     = r_inflight;
    assign err_spurious = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

    typedef struct packed {
        logic [15:0] bs;
        logic [15:0] bv;
        logic [3:0]  inf;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        issue_valid;
    logic [1:0]  issue_opType;
    logic [3:0]  issue_opCode, issue_rd, issue_rs1, issue_rs2;
    logic        issue_rs1_en, issue_rs2_en, issue_rs1_vec, issue_rs2_vec;
    logic        issue_ready;
    logic        wb_s_valid, wb_v_valid;
    logic [3:0]  wb_s_rd, wb_v_rd;
    logic        flush;
    logic [15:0] busy_s, busy_v;
    logic [3:0]  inflight;
    logic        err_spurious;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] m_bs = '0;
    logic [15:0] m_bv = '0;
    int          m_inf = 0;
    logic        m_err = 1'b0;
    exp_t        sb_q[$];

    reg_scoreboard #(.NREG(16), .MAX_INFLIGHT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_opType(issue_opType),
        .issue_opCode(issue_opCode), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_en(issue_rs1_en), .issue_rs2_en(issue_rs2_en),
        .issue_rs1_vec(issue_rs1_vec), .issue_rs2_vec(issue_rs2_vec),
        .issue_ready(issue_ready),
        .wb_s_valid(wb_s_valid), .wb_s_rd(wb_s_rd),
        .wb_v_valid(wb_v_valid), .wb_v_rd(wb_v_rd),
        .flush(flush),
        .busy_s(busy_s), .busy_v(busy_v),
        .inflight(inflight), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_opType = 0; issue_opCode = 0; issue_rd = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_rs1_en = 0; issue_rs2_en = 0;
        issue_rs1_vec = 0; issue_rs2_vec = 0;
        wb_s_valid = 0; wb_s_rd = 0; wb_v_valid = 0; wb_v_rd = 0; flush = 0;
    endtask

    task automatic iss(input logic [1:0] t, input logic [3:0] c, input logic [3:0] rd);
        issue_valid = 1; issue_opType = t; issue_opCode = c; issue_rd = rd;
    endtask

    task automatic src1(input logic [3:0] r, input logic vec);
        issue_rs1 = r; issue_rs1_en = 1; issue_rs1_vec = vec;
    endtask

    // 0 = no write, 1 = scalar file, 2 = vector file
    function automatic int wclass(input logic [1:0] t, input logic [3:0] c, input logic [3:0] rd);
        if (rd == 0) return 0;
        if (t[1] == 1'b0) return (c <= 9) ? 1 : 2;
        if (t == 2'b10 && c == 0) return 1;
        if (t == 2'b10 && c == 2) return 2;
        return 0;
    endfunction

    // One clock: check issue_ready against the model, push the expected
    // post-edge state, then pop and compare after the edge.
    task automatic step();
        logic [15:0] bes, bev, nbs, nbv;
        int   cls, ninf;
        logic raw, waw, lim, rdy, nerr;
        exp_t e;
        #1;
        bes = m_bs; bev = m_bv;
        if (wb_s_valid && wb_s_rd != 0) bes[wb_s_rd] = 1'b0;
        if (wb_v_valid && wb_v_rd != 0) bev[wb_v_rd] = 1'b0;
        cls = wclass(issue_opType, issue_opCode, issue_rd);
        raw = (issue_rs1_en && issue_rs1 != 0 && (issue_rs1_vec ? bev[issue_rs1] : bes[issue_rs1])) ||
              (issue_rs2_en && issue_rs2 != 0 && (issue_rs2_vec ? bev[issue_rs2] : bes[issue_rs2]));
        waw = (cls == 1 && bes[issue_rd]) || (cls == 2 && bev[issue_rd]);
        lim = (cls != 0) && (m_inf == 8);
        rdy = !flush && !raw && !waw && !lim;
        chk("issue_ready", {31'd0, issue_ready}, {31'd0, rdy});

        nbs = m_bs; nbv = m_bv; ninf = m_inf; nerr = 1'b0;
        if (flush) begin
            nbs = '0; nbv = '0; ninf = 0;
        end else begin
            if (wb_s_valid && wb_s_rd != 0) begin
                if (m_bs[wb_s_rd]) begin nbs[wb_s_rd] = 1'b0; ninf--; end
                else nerr = 1'b1;
            end
            if (wb_v_valid && wb_v_rd != 0) begin
                if (m_bv[wb_v_rd]) begin nbv[wb_v_rd] = 1'b0; ninf--; end
                else nerr = 1'b1;
            end
            if (issue_valid && rdy && cls == 1) begin nbs[issue_rd] = 1'b1; ninf++; end
            if (issue_valid && rdy && cls == 2) begin nbv[issue_rd] = 1'b1; ninf++; end
        end
        e.bs = nbs; e.bv = nbv; e.inf = 4'(ninf); e.err = nerr;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_queue_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("busy_s", {16'd0, busy_s}, {16'd0, e.bs});
            chk("busy_v", {16'd0, busy_v}, {16'd0, e.bv});
            chk("inflight", {28'd0, inflight}, {28'd0, e.inf});
            chk("err_spurious", {31'd0, err_spurious}, {31'd0, e.err});
            m_bs = e.bs; m_bv = e.bv; m_inf = int'(e.inf); m_err = e.err;
        end
        idle();
        @(negedge clk);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_busy_s"}, {16'd0, busy_s}, 32'd0);
        chk({tag, "_busy_v"}, {16'd0, busy_v}, 32'd0);
        chk({tag, "_inflight"}, {28'd0, inflight}, 32'd0);
        chk({tag, "_err"}, {31'd0, err_spurious}, 32'd0);
    endtask

    initial begin
        idle();
        #1 rst_n = 1'b0;
        #1;
        chk_cleared("reset");
        chk("reset_ready", {31'd0, issue_ready}, 32'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // scalar write rd=5, RAW on rs1=5 until writeback, bypass in wb cycle
        iss(2'b00, 4'd3, 4'd5); step();
        chk("t1_busy5", {31'd0, busy_s[5]}, 32'd1);
        chk("t1_inf", {28'd0, inflight}, 32'd1);
        iss(2'b00, 4'd3, 4'd6); src1(4'd5, 1'b0); step();
        iss(2'b00, 4'd3, 4'd6); src1(4'd5, 1'b0); step();
        iss(2'b00, 4'd3, 4'd6); src1(4'd5, 1'b0); wb_s_valid = 1; wb_s_rd = 5; step();
        chk("t1_busy6", {16'd0, busy_s}, 32'h0040);
        // same-register set and clear: bit stays, count net zero
        iss(2'b00, 4'd4, 4'd6); wb_s_valid = 1; wb_s_rd = 6; step();
        chk("setclr_busy6", {31'd0, busy_s[6]}, 32'd1);
        chk("setclr_inf", {28'd0, inflight}, 32'd1);
        wb_s_valid = 1; wb_s_rd = 6; step();

        // rd=0 writes nothing; source 0 never hazards
        iss(2'b00, 4'd3, 4'd0); step();
        chk("rd0_inf", {28'd0, inflight}, 32'd0);
        iss(2'b00, 4'd3, 4'd0); src1(4'd0, 1'b0); step();

        // vector load rd=7: scalar read of 7 free, vector read blocked
        iss(2'b10, 4'd2, 4'd7); step();
        chk("vld_busy7", {31'd0, busy_v[7]}, 32'd1);
        iss(2'b10, 4'd1, 4'd1); src1(4'd7, 1'b0); step();
        iss(2'b10, 4'd1, 4'd1); src1(4'd7, 1'b1); step();
        iss(2'b10, 4'd1, 4'd1); src1(4'd7, 1'b1); wb_v_valid = 1; wb_v_rd = 7; step();

        // fill to the in-flight limit
        for (int i = 1; i <= 8; i++) begin
            iss(2'b00, 4'd1, 4'(i)); step();
        end
        chk("full_inf", {28'd0, inflight}, 32'd8);
        iss(2'b00, 4'd1, 4'd9); step();
        iss(2'b01, 4'd12, 4'd10); step();
        iss(2'b10, 4'd1, 4'd9); step();
        // limit ignores the bypass
        iss(2'b00, 4'd1, 4'd9); wb_s_valid = 1; wb_s_rd = 1; step();

        // dual writeback, then spurious
        iss(2'b01, 4'd10, 4'd4); step();
        chk("v4_busy", {31'd0, busy_v[4]}, 32'd1);
        wb_s_valid = 1; wb_s_rd = 3; wb_v_valid = 1; wb_v_rd = 4; step();
        chk("dual_inf", {28'd0, inflight}, 32'd6);
        wb_s_valid = 1; wb_s_rd = 3; step();
        chk("spur_pulse", {31'd0, err_spurious}, 32'd1);
        chk("spur_inf", {28'd0, inflight}, 32'd6);
        step();
        chk("spur_drop", {31'd0, err_spurious}, 32'd0);
        wb_v_valid = 1; wb_v_rd = 0; step();

        // flush with a concurrent issue
        iss(2'b00, 4'd1, 4'd12); flush = 1; step();
        chk_cleared("flush");

        // randomized traffic over a small register window
        for (int n = 0; n < 300; n++) begin
            issue_valid   = ($urandom_range(0, 3) != 0);
            issue_opType  = 2'($urandom_range(0, 3));
            issue_opCode  = 4'($urandom_range(0, 15));
            issue_rd      = 4'($urandom_range(0, 7));
            issue_rs1     = 4'($urandom_range(0, 7));
            issue_rs2     = 4'($urandom_range(0, 7));
            issue_rs1_en  = 1'($urandom_range(0, 1));
            issue_rs2_en  = 1'($urandom_range(0, 1));
            issue_rs1_vec = 1'($urandom_range(0, 1));
            issue_rs2_vec = 1'($urandom_range(0, 1));
            wb_s_valid    = ($urandom_range(0, 2) == 0);
            wb_s_rd       = 4'($urandom_range(0, 7));
            wb_v_valid    = ($urandom_range(0, 2) == 0);
            wb_v_rd       = 4'($urandom_range(0, 7));
            flush         = ($urandom_range(0, 39) == 0);
            step();
        end

        // build pending state, then reset mid-traffic
        for (int i = 1; i <= 5; i++) begin
            iss(2'b00, 4'd2, 4'(i + 8)); step();
        end
        iss(2'b01, 4'd11, 4'd3); step();
        iss(2'b00, 4'd2, 4'd15); wb_s_valid = 1; wb_s_rd = 9;
        #2 rst_n = 1'b0;
        #1;
        chk_cleared("midreset");
        m_bs = '0; m_bv = '0; m_inf = 0; m_err = 1'b0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        iss(2'b00, 4'd2, 4'd9); step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
